reg_file_dump: RTL and testbench

REG_FILE_DUMP -- requirements
Module: reg_file_dump

---
 rtl/reg_file_dump.sv | 109 ++++++++++
 tb/tb_reg_file_dump.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dump.sv
// Streams a 16x16 register file out pairwise over a valid/ready port,
// accumulating a wrap-around checksum of every word accepted.
module reg_file_dump (
  input  logic        Clk,
  input  logic        Clear,
  input  logic        Start,
  output logic [3:0]  Aaddr,
  output logic [3:0]  Baddr,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] DataOut,
  output logic [3:0]  AddrOut,
  output logic        Valid,
  input  logic        Ready,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND_A,
    S_SEND_B,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  p_q, p_d;
  logic [15:0] hold_a_q, hold_a_d;
  logic [15:0] hold_b_q, hold_b_d;
  logic [15:0] csum_q, csum_d;

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q  <= S_IDLE;
      p_q      <= 3'd0;
      hold_a_q <= 16'd0;
      hold_b_q <= 16'd0;
      csum_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      csum_q   <= csum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    csum_d   = csum_q;
    Valid    = 1'b0;
    Done     = 1'b0;
    DataOut  = 16'd0;
    AddrOut  = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          p_d     = 3'd0;
          csum_d  = 16'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        hold_a_d = A;
        hold_b_d = B;
        state_d  = S_SEND_A;
      end
      S_SEND_A: begin
        Valid   = 1'b1;
        DataOut = hold_a_q;
        AddrOut = {p_q, 1'b0};
        if (Ready) begin
          csum_d  = csum_q + hold_a_q;
          state_d = S_SEND_B;
        end
      end
      S_SEND_B: begin
        Valid   = 1'b1;
        DataOut = hold_b_q;
        AddrOut = {p_q, 1'b1};
        if (Ready) begin
          csum_d = csum_q + hold_b_q;
          if (p_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            p_d     = p_q + 3'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Aaddr    = {p_q, 1'b0};
  assign Baddr    = {p_q, 1'b1};
  assign Busy     = (state_q != S_IDLE);
  assign Checksum = csum_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: ordering, stalls, wrap,
// ignored Start, mid-dump Clear and per-pair snapshot.
module tb_reg_file_dump;

  logic        Clk = 1'b0;
  logic        Clear;
  logic        Start;
  logic [3:0]  Aaddr, Baddr;
  logic [15:0] A, B;
  logic [15:0] DataOut;
  logic [3:0]  AddrOut;
  logic        Valid, Ready, Busy, Done;
  logic [15:0] Checksum;

  logic [15:0] regs [16];

  int checks = 0;
  int failures = 0;

  logic [15:0] got_data [32];
  logic [3:0]  got_addr [32];
  int          nwords, done_cyc, done_cnt, bad_idle, nstall;
  logic [15:0] st_data [8];
  logic [3:0]  st_addr [8];
  logic        st_vld  [8];

  always #5 Clk = ~Clk;

  assign A = regs[Aaddr];
  assign B = regs[Baddr];

  reg_file_dump dut (
    .Clk(Clk), .Clear(Clear), .Start(Start),
    .Aaddr(Aaddr), .Baddr(Baddr), .A(A), .B(B),
    .DataOut(DataOut), .AddrOut(AddrOut), .Valid(Valid),
    .Ready(Ready), .Busy(Busy), .Done(Done), .Checksum(Checksum)
  );

  task automatic preload(input logic [15:0] base, input bit inc);
    for (int i = 0; i < 16; i++)
      regs[i] = inc ? base + 16'(i) : base;
  endtask

  // Start one dump and watch it cycle by cycle from the falling edge.
  task automatic run_dump(input int stall_addr, input int stall_n,
                          input bit poke_start, input int clear_after,
                          input bit rewrite);
    int left;
    bit stalling, poked_b;
    nwords = 0; done_cyc = -1; done_cnt = 0;
    bad_idle = 0; nstall = 0;
    left = stall_n; stalling = 0; poked_b = 0;
    @(negedge Clk);
    Start = 1'b1;
    Ready = 1'b1;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge Clk);
      Start = 1'b0;
      Ready = 1'b1;
      if (clear_after >= 0 && nwords == clear_after) begin
        Clear = 1'b1;
        break;
      end
      if (rewrite && Valid && AddrOut == 4'd4) regs[5] = 16'hBEEF;
      if (left > 0 && (stalling || (Valid && AddrOut == 4'(stall_addr)))) begin
        stalling = 1;
        Ready = 1'b0;
        left--;
        st_data[nstall] = DataOut;
        st_addr[nstall] = AddrOut;
        st_vld[nstall]  = Valid;
        nstall++;
      end
      if (!Valid && (DataOut != 16'd0 || AddrOut != 4'd0)) bad_idle++;
      if (Valid && Ready && nwords < 32) begin
        got_data[nwords] = DataOut;
        got_addr[nwords] = AddrOut;
        nwords++;
      end
      if (Done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (poke_start && Valid && AddrOut == 4'd3 && !poked_b) begin
        Start = 1'b1;
        poked_b = 1;
      end
      if (poke_start && Done) Start = 1'b1;
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    Clear = 1'b1; Start = 1'b0; Ready = 1'b1;
    #1;
    checks++; if (Valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b exp=0", Valid); end
    checks++; if (Busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin failures++;
      $display("FAIL reset_done got=%b exp=0", Done); end
    checks++; if (Checksum !== 16'd0) begin failures++;
      $display("FAIL reset_csum got=%h exp=0000", Checksum); end
    checks++; if (DataOut !== 16'd0 || AddrOut !== 4'd0) begin failures++;
      $display("FAIL reset_out got=%h/%h exp=0000/0", DataOut, AddrOut); end
    checks++; if (Aaddr !== 4'd0 || Baddr !== 4'd1) begin failures++;
      $display("FAIL reset_addr got=%h/%h exp=0/1", Aaddr, Baddr); end
    @(negedge Clk); Start = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin failures++;
      $display("FAIL start_in_clear busy got=%b exp=0", Busy); end
    Start = 1'b0;
    @(negedge Clk); Clear = 1'b0;
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin failures++;
      $display("FAIL idle_after_clear busy got=%b exp=0", Busy); end
  endtask

  task automatic test_basic;
    preload(16'h1000, 1);
    run_dump(-1, 0, 0, -1, 0);
    checks++; if (nwords != 16) begin failures++;
      $display("FAIL basic_count got=%0d exp=16", nwords); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_data[i] !== 16'h1000 + 16'(i) || got_addr[i] !== 4'(i)) begin
        failures++;
        $display("FAIL basic_word%0d got=%h@%h exp=%h@%h", i,
                 got_data[i], got_addr[i], 16'h1000 + 16'(i), 4'(i));
      end
    end
    checks++; if (done_cyc != 25) begin failures++;
      $display("FAIL basic_done_cycle got=%0d exp=25", done_cyc); end
    checks++; if (done_cnt != 1) begin failures++;
      $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    checks++; if (Checksum !== 16'h0078) begin failures++;
      $display("FAIL basic_csum got=%h exp=0078", Checksum); end
    checks++; if (bad_idle != 0) begin failures++;
      $display("FAIL basic_idle_zero got=%0d exp=0", bad_idle); end
    checks++; if (Busy !== 1'b0) begin failures++;
      $display("FAIL basic_busy_end got=%b exp=0", Busy); end
  endtask

  task automatic test_stall;
    preload(16'h1000, 1);
    run_dump(6, 5, 0, -1, 0);
    checks++; if (nstall != 5) begin failures++;
      $display("FAIL stall_count got=%0d exp=5", nstall); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (st_vld[i] !== 1'b1 || st_data[i] !== 16'h1006 || st_addr[i] !== 4'd6) begin
        failures++;
        $display("FAIL stall_hold%0d got=%b %h@%h exp=1 1006@6", i,
                 st_vld[i], st_data[i], st_addr[i]);
      end
    end
    checks++; if (nwords != 16) begin failures++;
      $display("FAIL stall_words got=%0d exp=16", nwords); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_data[i] !== 16'h1000 + 16'(i) || got_addr[i] !== 4'(i)) begin
        failures++;
        $display("FAIL stall_word%0d got=%h@%h", i, got_data[i], got_addr[i]);
      end
    end
    checks++; if (done_cyc != 30) begin failures++;
      $display("FAIL stall_done_cycle got=%0d exp=30", done_cyc); end
    checks++; if (Checksum !== 16'h0078) begin failures++;
      $display("FAIL stall_csum got=%h exp=0078", Checksum); end
  endtask

  task automatic test_wrap;
    preload(16'hFFFF, 0);
    run_dump(-1, 0, 0, -1, 0);
    checks++; if (Checksum !== 16'hFFF0) begin failures++;
      $display("FAIL wrap_csum got=%h exp=fff0", Checksum); end
    checks++; if (nwords != 16) begin failures++;
      $display("FAIL wrap_words got=%0d exp=16", nwords); end
  endtask

  task automatic test_start_ignored;
    preload(16'h1000, 1);
    run_dump(-1, 0, 1, -1, 0);
    checks++; if (done_cnt != 1) begin failures++;
      $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
    checks++; if (nwords != 16) begin failures++;
      $display("FAIL ign_words got=%0d exp=16", nwords); end
    checks++; if (Busy !== 1'b0) begin failures++;
      $display("FAIL ign_busy_end got=%b exp=0", Busy); end
    checks++; if (Checksum !== 16'h0078) begin failures++;
      $display("FAIL ign_csum got=%h exp=0078", Checksum); end
  endtask

  task automatic test_clear_mid;
    preload(16'h1000, 1);
    run_dump(-1, 0, 0, 6, 0);
    #1;
    checks++; if (Valid !== 1'b0 || Busy !== 1'b0) begin failures++;
      $display("FAIL clr_async got=v%b b%b exp=v0 b0", Valid, Busy); end
    checks++; if (Checksum !== 16'd0 || DataOut !== 16'd0) begin failures++;
      $display("FAIL clr_zero got=%h/%h exp=0000/0000", Checksum, DataOut); end
    @(negedge Clk);
    checks++; if (Done !== 1'b0 || Valid !== 1'b0) begin failures++;
      $display("FAIL clr_quiet got=d%b v%b exp=d0 v0", Done, Valid); end
    Clear = 1'b0;
    run_dump(-1, 0, 0, -1, 0);
    checks++; if (got_addr[0] !== 4'd0 || got_data[0] !== 16'h1000) begin
      failures++;
      $display("FAIL clr_restart got=%h@%h exp=1000@0", got_data[0], got_addr[0]);
    end
    checks++; if (nwords != 16 || Checksum !== 16'h0078) begin failures++;
      $display("FAIL clr_redump got=%0d/%h exp=16/0078", nwords, Checksum); end
  endtask

  task automatic test_snapshot;
    preload(16'h1000, 1);
    run_dump(-1, 0, 0, -1, 1);
    checks++; if (got_data[5] !== 16'h1005) begin failures++;
      $display("FAIL snap_word5 got=%h exp=1005", got_data[5]); end
    checks++; if (Checksum !== 16'h0078) begin failures++;
      $display("FAIL snap_csum got=%h exp=0078", Checksum); end
  endtask

  initial begin
    Clear = 1'b1; Start = 1'b0; Ready = 1'b1;
    preload(16'h0000, 1);
    test_reset;
    test_basic;
    test_stall;
    test_wrap;
    test_start_ignored;
    test_clear_mid;
    test_snapshot;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
